// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// used by both the TX and RX sides of the link.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP,
    UART_BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is
// a parameter so idle-high lines do not look active coming out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes rx, finds the start bit, samples each bit
// mid-period and emits the byte with a one-cycle valid or framing-error strobe.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q,  data_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      UART_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = UART_START;
      end
      UART_START: begin
        // Half-bit recheck rejects glitches and aligns later samples to mid-bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = UART_IDLE;
          end else begin
            state_d = UART_DATA;
            idx_d   = '0;
          end
        end
      end
      UART_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) state_d = UART_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end
      end
      UART_STOP: begin
        // Leaving at mid-stop-bit lets a following start bit be caught with no gap.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = UART_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = UART_BREAK;
          end
        end
      end
      UART_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = UART_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = UART_IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized self-checking bench for uart_rx_deserializer with a 16-clock bit period.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int C = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_deserializer #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Monitor: records every strobe seen on the outputs.
  logic [7:0] got_q[$];
  int         got_t[$];
  int         cyc = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         wide_cnt = 0;
  bit         prev_v = 1'b0;
  bit         prev_e = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (data_valid) begin
        got_q.push_back(data_out);
        got_t.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (data_valid && frame_err) both_cnt++;
      if ((data_valid && prev_v) || (frame_err && prev_e)) wide_cnt++;
      prev_v = data_valid;
      prev_e = frame_err;
    end else begin
      prev_v = 1'b0;
      prev_e = 1'b0;
    end
  end

  logic [7:0] last_good = 8'h00;

  // Drive one 8N1 frame; skew is in parts per thousand of the nominal bit time.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int skew);
    logic [9:0] bits;
    int prev, endc;
    bits = {stop, b, 1'b0};
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      endc = ((k + 1) * C * (1000 + skew)) / 1000;
      rx = bits[k];
      repeat (endc - prev) @(negedge clk);
      prev = endc;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    ferr_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_values: got data=%h v=%b e=%b busy=%b want 00 0 0 0",
               data_out, data_valid, frame_err, busy);
    else n_pass++;
    clear_mon();
    rst_n = 1'b1;
    // Line stays low after reset: seen as a start bit, ends in a framing error.
    repeat (6) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL low_after_reset_busy: got %b want 1", busy);
    else n_pass++;
    repeat (12 * C) @(negedge clk);
    n_total++;
    if (ferr_cnt != 1 || got_q.size() != 0)
      $display("FAIL low_after_reset_err: got ferr=%0d valid=%0d want 1 0", ferr_cnt, got_q.size());
    else n_pass++;
    idle(2 * C);
    n_total++;
    if (busy !== 1'b0) $display("FAIL low_after_reset_idle: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'hA5, 1'b1, 0);
    idle(2 * C);
    last_good = 8'hA5;
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5)
      $display("FAIL single_byte: got n=%0d first=%h want 1 a5", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'hxx);
    else n_pass++;
    n_total++;
    if (data_out !== 8'hA5 || ferr_cnt != 0 || busy !== 1'b0)
      $display("FAIL single_hold: got data=%h ferr=%0d busy=%b want a5 0 0", data_out, ferr_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dt;
    clear_mon();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(2 * C);
    last_good = 8'hFF;
    n_total++;
    if (got_q.size() != 2 || got_q[0] !== 8'h00 || got_q[1] !== 8'hFF)
      $display("FAIL b2b_data: got n=%0d want 2 bytes 00 ff", got_q.size());
    else n_pass++;
    dt = (got_t.size() == 2) ? got_t[1] - got_t[0] : -1;
    n_total++;
    if (dt < 10 * C - 1 || dt > 10 * C + 1)
      $display("FAIL b2b_spacing: got %0d clks want %0d+-1", dt, 10 * C);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int busy_cycles;
    clear_mon();
    busy_cycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    rx = 1'b1;
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    n_total++;
    if (busy_cycles == 0 || busy_cycles > C / 2)
      $display("FAIL glitch_busy: got %0d busy cycles want 1..%0d", busy_cycles, C / 2);
    else n_pass++;
    n_total++;
    if (got_q.size() != 0 || ferr_cnt != 0 || busy !== 1'b0 || data_out !== last_good)
      $display("FAIL glitch_quiet: got valid=%0d ferr=%0d busy=%b data=%h want 0 0 0 %h",
               got_q.size(), ferr_cnt, busy, data_out, last_good);
    else n_pass++;
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h3C, 1'b0, 0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    n_total++;
    if (ferr_cnt != 1 || got_q.size() != 0 || data_out !== last_good)
      $display("FAIL ferr_pulse: got ferr=%0d valid=%0d data=%h want 1 0 %h",
               ferr_cnt, got_q.size(), data_out, last_good);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b want 1", busy);
    else n_pass++;
    idle(2 * C);
    n_total++;
    if (busy !== 1'b0) $display("FAIL ferr_release: got busy=%b want 0", busy);
    else n_pass++;
    send_frame(8'h81, 1'b1, 0);
    idle(2 * C);
    last_good = 8'h81;
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81 || ferr_cnt != 1)
      $display("FAIL ferr_recover: got n=%0d ferr=%0d want one 81 and ferr 1", got_q.size(), ferr_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    bit bad;
    clear_mon();
    b = 8'hC3;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx = b[k];
      repeat (C) @(negedge clk);
    end
    rx = b[4];
    repeat (C / 2) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    bad   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0)
        bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL midreset_values: got data=%h busy=%b want 00 0 throughout", data_out, busy);
    else n_pass++;
    rst_n = 1'b1;
    last_good = 8'h00;
    idle(C);
    send_frame(8'h5A, 1'b1, 0);
    idle(2 * C);
    last_good = 8'h5A;
    n_total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A || ferr_cnt != 0)
      $display("FAIL midreset_next: got n=%0d ferr=%0d want one 5a", got_q.size(), ferr_cnt);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int skew;
    int nbad;
    clear_mon();
    for (int i = 0; i < 200; i++) begin
      b    = 8'($urandom);
      skew = int'($urandom_range(40)) - 20;
      send_frame(b, 1'b1, skew);
      exp_q.push_back(b);
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2 * C)));
    end
    idle(2 * C);
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL stream_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) nbad++;
    n_total++;
    if (nbad != 0) $display("FAIL stream_bytes: got %0d wrong bytes want 0", nbad);
    else n_pass++;
    n_total++;
    if (ferr_cnt != 0) $display("FAIL stream_ferr: got %0d want 0", ferr_cnt);
    else n_pass++;
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    n_total++;
    if (data_out !== last_good) $display("FAIL stream_hold: got %h want %h", data_out, last_good);
    else n_pass++;
  endtask

  task automatic test_strobe_rules();
    n_total++;
    if (both_cnt != 0 || wide_cnt != 0)
      $display("FAIL strobe_rules: got overlap=%0d wide=%0d want 0 0", both_cnt, wide_cnt);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_mid_reset();
    test_random_stream();
    test_strobe_rules();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
